// File: rtl/adain_feeder.sv
// adain_feeder
//   Buffers one channel of N samples and sequences them into an AdaIN core:
//   a statistics pass (mean pass, then variance replay), a wait for the
//   statistics to complete, and a normalize pass whose issue rate is
//   throttled so results can never overflow the output FIFO.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   job_start, job_N, job_ys/yb   job command (accepted only while idle)
//   s_data/s_valid/s_ready        input sample stream
//   m_data/m_valid/m_ready        normalized output stream
//   busy                          job in progress
//   ad_start, ad_N, ad_in,
//   ad_ys, ad_yb                  command/data towards the AdaIN core
//   ad_out, ad_done               results/status from the AdaIN core
module adain_feeder #(
  parameter int WIDTH_IN    = 48,
  parameter int WIDTH_OUT   = 16,
  parameter int N_MAX       = 256,
  parameter int LAT         = 3,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_start,
  input  logic [$clog2(N_MAX+1)-1:0]   job_N,
  input  logic [WIDTH_IN-1:0]          job_ys,
  input  logic [WIDTH_IN-1:0]          job_yb,
  input  logic [WIDTH_IN-1:0]          s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [WIDTH_OUT-1:0]         m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic [1:0]                   ad_start,
  output logic [$clog2(N_MAX+1)-1:0]   ad_N,
  output logic [WIDTH_IN-1:0]          ad_in,
  output logic [WIDTH_IN-1:0]          ad_ys,
  output logic [WIDTH_IN-1:0]          ad_yb,
  input  logic [WIDTH_OUT-1:0]         ad_out,
  input  logic [1:0]                   ad_done
);

  localparam int NW = $clog2(N_MAX + 1);
  localparam int AB = $clog2(N_MAX);
  localparam int FW = $clog2(OFIFO_DEPTH + 1);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam logic [FW:0] DEPTH_C = (FW+1)'(OFIFO_DEPTH);

  // Results still in the core must always have a FIFO slot waiting.
  if (OFIFO_DEPTH <= LAT) begin : g_bad_depth
    $error("adain_feeder: OFIFO_DEPTH must exceed LAT");
  end

  typedef enum logic [2:0] {IDLE, LOAD, MEAN, VAR, WAIT_ST, NORM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [NW-1:0]        n_reg, wr_addr, rd_addr, out_cnt;
  logic [WIDTH_IN-1:0]  ys_reg, yb_reg;
  logic [FW-1:0]        inflight, ofifo_count;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [WIDTH_IN-1:0]  buf_mem   [N_MAX];
  logic [WIDTH_OUT-1:0] ofifo_mem [OFIFO_DEPTH];

  logic drive, issue, job_go, load_beat, push, pop, rd_last, room;

  assign load_beat = s_valid && s_ready;
  // A result is only accepted while something is outstanding, so pulses
  // left over from an aborted job are dropped after reset.
  assign push      = (ad_done == 2'b10) && (inflight != '0);
  assign pop       = m_valid && m_ready;
  assign rd_last   = (rd_addr == n_reg - NW'(1));
  assign room      = ({1'b0, ofifo_count} + {1'b0, inflight}) < DEPTH_C;

  always_comb begin
    state_nxt = state;
    drive     = 1'b0;
    issue     = 1'b0;
    job_go    = 1'b0;
    ad_start  = 2'b00;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (job_start) begin
          job_go    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && (wr_addr == n_reg - NW'(1))) state_nxt = MEAN;
      end
      MEAN: begin
        drive = 1'b1;
        if (rd_addr == '0) ad_start = 2'b01;
        if (rd_last) state_nxt = VAR;
      end
      VAR: begin
        drive = 1'b1;
        if (rd_last) state_nxt = WAIT_ST;
      end
      WAIT_ST: begin
        if (ad_done == 2'b01) state_nxt = NORM;
      end
      NORM: begin
        if (room) begin
          issue = 1'b1;
          drive = 1'b1;
          if (rd_addr == '0) ad_start = 2'b10;
          if (rd_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && (ofifo_count == '0) && (out_cnt == n_reg))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      n_reg       <= '0;
      ys_reg      <= '0;
      yb_reg      <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      out_cnt     <= '0;
      inflight    <= '0;
      ofifo_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (job_go) begin
        n_reg   <= job_N;
        ys_reg  <= job_ys;
        yb_reg  <= job_yb;
        wr_addr <= '0;
        rd_addr <= '0;
        out_cnt <= '0;
      end
      if (load_beat) wr_addr <= wr_addr + NW'(1);
      // Read address restarts at 0 after each full pass (MEAN, VAR, NORM).
      if (drive) rd_addr <= rd_last ? '0 : rd_addr + NW'(1);
      if (pop) out_cnt <= out_cnt + NW'(1);
      case ({issue, push})
        2'b10:   inflight <= inflight + FW'(1);
        2'b01:   inflight <= inflight - FW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   ofifo_count <= ofifo_count + FW'(1);
        2'b01:   ofifo_count <= ofifo_count - FW'(1);
        default: ofifo_count <= ofifo_count;
      endcase
      if (push) wr_ptr <= (wr_ptr == AW'(OFIFO_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(OFIFO_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (load_beat) buf_mem[wr_addr[AB-1:0]] <= s_data;
    if (push)      ofifo_mem[wr_ptr]        <= ad_out;
  end

  assign ad_in   = drive ? buf_mem[rd_addr[AB-1:0]] : '0;
  assign ad_N    = n_reg;
  assign ad_ys   = ys_reg;
  assign ad_yb   = yb_reg;
  assign busy    = (state != IDLE);
  assign m_valid = (ofifo_count != '0);
  assign m_data  = m_valid ? ofifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adain_feeder.sv
`timescale 1ns/1ps
module tb_adain_feeder;
  localparam int WI  = 48;
  localparam int WO  = 16;
  localparam int NM  = 256;
  localparam int LAT = 3;
  localparam int OD  = 8;
  localparam int NW  = $clog2(NM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [NW-1:0] job_N;
  logic [WI-1:0] job_ys, job_yb, s_data;
  logic          s_valid, s_ready;
  logic [WO-1:0] m_data;
  logic          m_valid, m_ready, busy;
  logic [1:0]    ad_start;
  logic [NW-1:0] ad_N;
  logic [WI-1:0] ad_in, ad_ys, ad_yb;
  logic [WO-1:0] ad_out;
  logic [1:0]    ad_done;

  adain_feeder #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .N_MAX(NM), .LAT(LAT), .OFIFO_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_N(job_N), .job_ys(job_ys),
    .job_yb(job_yb), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .ad_start(ad_start), .ad_N(ad_N), .ad_in(ad_in), .ad_ys(ad_ys), .ad_yb(ad_yb),
    .ad_out(ad_out), .ad_done(ad_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_n  = 1;
  int max_out;
  logic [WI-1:0] samp [NM];
  logic [WI-1:0] trace [$];
  logic [WI-1:0] iss_q [$];
  logic [WO-1:0] got   [$];
  bit            ev01  [$];
  bit            ev10  [$];

  // AdaIN core stand-in: statistics complete a few cycles after the 2N
  // statistics samples; each normalize sample returns LAT cycles later as
  // integer part of the sample plus integer part of ys.
  logic           rec_on   = 1'b0;
  int             rec_n    = 0;
  int             wait_cnt = 0;
  logic [1:0]     st_code  = 2'b00;
  logic           norm_ph  = 1'b0;
  logic [LAT-1:0] pv       = '0;
  logic [WO-1:0]  pd [LAT];
  logic [WI-1:0]  gap_val  = '0;
  int             cyc      = 0;
  int             last_pop = 0;
  wire            issue_seen = (ad_start == 2'b10) || (norm_ph && (ad_in != '0));

  assign ad_done = pv[LAT-1] ? 2'b10 : st_code;
  assign ad_out  = pv[LAT-1] ? pd[LAT-1] : '0;

  function automatic logic [WO-1:0] norm_f(input logic [WI-1:0] s, input logic [WI-1:0] ys);
    return s[31:16] + ys[31:16];
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pv    <= {pv[LAT-2:0], issue_seen};
    pd[0] <= norm_f(ad_in, ad_ys);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    if (issue_seen) iss_q.push_back(ad_in);
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      last_pop <= cyc + 1;
    end
    if (rst) begin
      rec_on   <= 1'b0;
      rec_n    <= 0;
      wait_cnt <= 0;
      st_code  <= 2'b00;
      norm_ph  <= 1'b0;
    end else begin
      st_code <= 2'b00;
      if (!busy) norm_ph <= 1'b0;
      if (ad_start == 2'b10) ev10.push_back(1'b1);
      if (ad_start == 2'b01) begin
        ev01.push_back(1'b1);
        trace.push_back(ad_in);
        rec_on <= 1'b1;
        rec_n  <= 1;
      end else if (rec_on) begin
        trace.push_back(ad_in);
        rec_n <= rec_n + 1;
        if (rec_n + 1 >= 2 * cur_n) begin
          rec_on   <= 1'b0;
          wait_cnt <= 4;
        end
      end else if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
        if (wait_cnt == 4) gap_val <= ad_in;
        if (wait_cnt == 2) st_code <= 2'b11;
        if (wait_cnt == 1) begin
          st_code <= 2'b01;
          norm_ph <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int n, input logic [WI-1:0] ys, input logic [WI-1:0] yb);
    cur_n = n;
    trace.delete(); iss_q.delete(); got.delete(); ev01.delete(); ev10.delete();
    max_out   = 0;
    job_N     = NW'(n);
    job_ys    = ys;
    job_yb    = yb;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic load(input int n, input bit gaps, input bit poke);
    int idx = 0;
    int g   = 0;
    while (idx < n && g < 5000) begin
      if (gaps && $urandom_range(0, 2) == 0) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = samp[idx];
        if (s_ready) idx++;
      end
      if (poke && idx == 2) begin
        job_start = 1'b1; job_N = NW'(3); job_ys = '1; job_yb = '1;
      end else job_start = 1'b0;
      @(negedge clk);
      g++;
    end
    s_valid = 1'b0; s_data = '0; job_start = 1'b0;
    chk("load_complete", (idx == n), 1);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int g = 0;
    while (busy && g < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
      if (iss_q.size() - got.size() > max_out) max_out = iss_q.size() - got.size();
    end
    chk("job_finished", busy, 0);
    m_ready = 1'b1;
  endtask

  task automatic check_job(input string nm, input int n, input logic [WI-1:0] ys, input bit fall);
    int bad_t = 0;
    int bad_o = 0;
    int bad_i = 0;
    chk({nm, "_trace_len"}, trace.size(), 2 * n);
    for (int i = 0; i < trace.size() && i < 2 * n; i++) if (trace[i] !== samp[i % n]) bad_t++;
    chk({nm, "_trace_bad"}, bad_t, 0);
    chk({nm, "_gap_ad_in"}, gap_val, 0);
    chk({nm, "_start01"}, ev01.size(), 1);
    chk({nm, "_start10"}, ev10.size(), 1);
    chk({nm, "_issued"}, iss_q.size(), n);
    for (int i = 0; i < iss_q.size() && i < n; i++) if (iss_q[i] !== samp[i]) bad_i++;
    chk({nm, "_issue_order"}, bad_i, 0);
    chk({nm, "_out_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) if (got[i] !== norm_f(samp[i], ys)) bad_o++;
    chk({nm, "_out_bad"}, bad_o, 0);
    chk({nm, "_no_overflow"}, (max_out <= OD), 1);
    if (fall) chk({nm, "_busy_fall"}, cyc - last_pop, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; job_start = 1'b0; job_N = '0; job_ys = '0; job_yb = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ad_start", ad_start, 0);
    chk("rst_ad_in", ad_in, 0);
    chk("rst_ad_N", ad_N, 0);
    chk("rst_ad_ys", ad_ys, 0);
    chk("rst_ad_yb", ad_yb, 0);
    chk("rst_m_data", m_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // N=4, samples 1..4 in Q16, ys=2.0 -> outputs 3,4,5,6
    for (int i = 0; i < 4; i++) samp[i] = WI'(i + 1) << 16;
    start_job(4, WI'(2) << 16, WI'(5) << 16);
    chk("load_s_ready", s_ready, 1);
    load(4, 1'b0, 1'b0);
    chk("mean_first_start", ad_start, 2'b01);
    chk("mean_first_ad_in", ad_in, WI'(1) << 16);
    wait_done(200, 1'b0);
    check_job("n4", 4, WI'(2) << 16, 1'b1);
    chk("n4_out0", (got.size() > 0) ? got[0] : 16'hdead, 16'd3);
    chk("n4_out3", (got.size() > 3) ? got[3] : 16'hdead, 16'd6);

    // N=256 with random s_valid gaps and random m_ready
    for (int i = 0; i < NM; i++) samp[i] = {16'h0, 16'($urandom_range(1, 65535)), 16'($urandom)};
    start_job(NM, WI'(7) << 16, WI'(1) << 16);
    load(NM, 1'b1, 1'b0);
    wait_done(6000, 1'b1);
    check_job("n256", NM, WI'(7) << 16, 1'b0);

    // N=16 with m_ready low during NORM, plus job_start poked during LOAD
    for (int i = 0; i < 16; i++) samp[i] = WI'(i + 10) << 16;
    m_ready = 1'b0;
    start_job(16, WI'(3) << 16, WI'(9) << 16);
    load(16, 1'b0, 1'b1);
    chk("poke_ad_N", ad_N, 16);
    chk("poke_ad_ys", ad_ys, WI'(3) << 16);
    chk("poke_ad_yb", ad_yb, WI'(9) << 16);
    begin
      int g = 0;
      while (iss_q.size() < 8 && g < 300) begin @(negedge clk); g++; end
    end
    repeat (20) @(negedge clk);
    chk("stall_issued", iss_q.size(), 8);
    chk("stall_popped", got.size(), 0);
    chk("stall_m_valid", m_valid, 1);
    chk("stall_busy", busy, 1);
    max_out = iss_q.size() - got.size();
    m_ready = 1'b1;
    wait_done(500, 1'b0);
    check_job("n16", 16, WI'(3) << 16, 1'b1);
    chk("n16_peak_outstanding", max_out, OD);

    // N=1
    samp[0] = WI'(40) << 16;
    start_job(1, WI'(1) << 16, '0);
    load(1, 1'b0, 1'b0);
    chk("n1_mean_start", ad_start, 2'b01);
    wait_done(100, 1'b0);
    check_job("n1", 1, WI'(1) << 16, 1'b1);
    chk("n1_out", (got.size() > 0) ? got[0] : 16'hdead, 16'd41);

    // Reset during NORM with 3 samples issued, then a fresh job
    for (int i = 0; i < 8; i++) samp[i] = WI'(i + 20) << 16;
    start_job(8, WI'(1) << 16, '0);
    load(8, 1'b0, 1'b0);
    begin
      int g = 0;
      while (iss_q.size() < 3 && g < 300) begin @(negedge clk); g++; end
    end
    chk("abort_issued", iss_q.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_ad_in", ad_in, 0);
    rst = 1'b0;
    got.delete();
    begin
      int mv = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (m_valid) mv++;
      end
      chk("abort_late_m_valid", mv, 0);
    end
    chk("abort_late_out", got.size(), 0);
    for (int i = 0; i < 5; i++) samp[i] = WI'(i + 50) << 16;
    start_job(5, WI'(4) << 16, WI'(2) << 16);
    load(5, 1'b0, 1'b0);
    wait_done(200, 1'b0);
    check_job("after_abort", 5, WI'(4) << 16, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adain_feeder.md
ADAIN_FEEDER -- requirements
Module: adain_feeder

Interface
REQ-001 Parameter WIDTH_IN, default 48, sample/style width (Q.FRAC_BITS_IN fixed point).
REQ-002 Parameter WIDTH_OUT, default 16, normalized output width.
REQ-003 Parameter N_MAX, default 256, maximum samples per channel; buffer depth.
REQ-004 Parameter LAT, default 3, cycles from driving a normalize sample to its out/done=2'b10 from the AdaIN core.
REQ-005 Parameter OFIFO_DEPTH, default 8, output FIFO depth; SHALL be greater than LAT.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 job_start  in  1  one-cycle pulse; latches job_N, job_ys, job_yb; ignored unless busy=0.
REQ-009 job_N  in  clog2(N_MAX+1)  channel sample count, legal range 1..N_MAX.
REQ-010 job_ys / job_yb  in  WIDTH_IN each  style scale / bias for the job.
REQ-011 s_data, s_valid, s_ready  in/in/out  WIDTH_IN/1/1  input sample stream; beat transfers when s_valid and s_ready are both 1.
REQ-012 m_data, m_valid, m_ready  out/out/in  WIDTH_OUT/1/1  normalized output stream with the same handshake.
REQ-013 busy  out  1  high from an accepted job_start until the last m_data beat transfers.
REQ-014 ad_start  out  2  AdaIN command: 00 none, 01 statistics pass, 10 normalize pass.
REQ-015 ad_N  out  clog2(N_MAX+1)  latched job_N.
REQ-016 ad_in, ad_ys, ad_yb  out  WIDTH_IN each  sample, latched ys, latched yb.
REQ-017 ad_out  in  WIDTH_OUT  AdaIN result.
REQ-018 ad_done  in  2  00 none, 01 statistics complete, 10 output sample valid.

Function
REQ-019 States: IDLE, LOAD, MEAN, VAR, WAIT_ST, NORM, DRAIN.
REQ-020 IDLE -> LOAD on job_start; latches N, ys, yb; clears address and count registers.
REQ-021 LOAD: s_ready=1; each beat is written to buffer[wr_addr] and wr_addr increments; after the N-th beat -> MEAN.
REQ-022 MEAN: ad_start=01 for exactly one cycle, aligned with sample 0 on ad_in; samples 0..N-1 are driven on consecutive cycles with no gaps; then -> VAR.
REQ-023 VAR: samples 0..N-1 are replayed on consecutive cycles with ad_start=00; then -> WAIT_ST.
REQ-024 WAIT_ST: waits for ad_done=01, then -> NORM; any other ad_done value is ignored.
REQ-025 NORM: ad_start=10 accompanies the first issued sample only.
REQ-026 NORM issue rule: a sample is issued in a cycle only when ofifo_count + inflight < OFIFO_DEPTH.
REQ-027 inflight counts issued samples whose ad_done=10 has not yet returned.
REQ-028 After N samples have been issued, NORM -> DRAIN.
REQ-029 Each ad_done=10 pushes ad_out into the output FIFO, in any state.
REQ-030 Overflow of the output FIFO is unreachable by REQ-026; the bench SHALL assert it never occurs.
REQ-031 DRAIN -> IDLE when inflight=0, the output FIFO is empty, and all N output beats have transferred.
REQ-032 m_valid = output FIFO not empty; m_data = FIFO head; pop occurs on m_valid and m_ready.
REQ-033 Push and pop in the same cycle leave ofifo_count unchanged.
REQ-034 Output order equals input order.
REQ-035 Exactly N m_data beats are produced per job.
REQ-036 ad_in = 0 whenever no sample is being driven.
REQ-037 s_ready = 0 outside LOAD.
REQ-038 job_start while busy=1 is ignored, with no state change.
REQ-039 Minimum job latency: N load beats, 2N statistics cycles, the stats wait, then N+LAT cycles with m_ready held at 1.
REQ-040 N=1 is legal: one load beat, one MEAN cycle, one VAR cycle, one output.
REQ-041 N=N_MAX fills the buffer exactly; address counters SHALL NOT wrap within a job.

Reset
REQ-042 On rst=1: state=IDLE; all counters zero; output FIFO empty.
REQ-043 On rst=1, outputs: busy=0, s_ready=0, m_valid=0, ad_start=00, ad_in=0, ad_N=0, ad_ys=0, ad_yb=0, m_data=0.
REQ-044 Reset mid-job aborts the job immediately; ad_done pulses arriving afterwards are ignored until the next job.
REQ-045 Buffer contents need not be cleared by reset.

Verification
REQ-046 N=4, samples 1,2,3,4 (Q16), m_ready=1, AdaIN model -> MEAN and VAR each replay 1,2,3,4; ad_start=01 once and 10 once; 4 outputs in order; busy falls 1 cycle after the last beat.
REQ-047 N=256 load with random s_valid gaps -> all 256 samples replayed twice exactly; 256 outputs; no address wrap.
REQ-048 N=16, m_ready=0 throughout NORM -> issue halts with exactly 8 results outstanding (FIFO + inflight); no overflow; releasing m_ready completes all 16.
REQ-049 N=1 -> single-cycle MEAN and VAR; one output; return to IDLE.
REQ-050 job_start pulsed during LOAD -> ignored; N, ys, yb unchanged.
REQ-051 rst asserted during NORM with 3 samples in flight -> next cycle IDLE, m_valid=0; late ad_done=10 pulses produce no output; a new job then runs correctly.
